// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID pipeline buffer with flush and stall counter.
// Define IF_ID_SKID_EN to add a skid entry that makes in_ready a pure register output.
`timescale 1ns/1ps
module if_id_buffer #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef IF_ID_SKID_EN
  localparam logic [1:0] ST_FULL  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`ifdef IF_ID_SKID_EN
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
`endif
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
`ifdef IF_ID_SKID_EN
  assign in_ready  = (state_q != ST_FULL);
`else
  assign in_ready  = !out_valid || out_ready;
`endif
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Empty buffer presents zeros so decode sees a NOP.
  assign out_pc      = out_valid ? main_pc_q : '0;
  assign out_inst    = out_valid ? main_inst_q : '0;
  assign out_pc_next = out_pc + 1'b1;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
`ifdef IF_ID_SKID_EN
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
`endif
    if (flush) begin
      state_d     = ST_EMPTY;
      main_pc_d   = '0;
      main_inst_d = '0;
`ifdef IF_ID_SKID_EN
      skid_pc_d   = '0;
      skid_inst_d = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
`ifdef IF_ID_SKID_EN
          end else if (in_fire) begin
            state_d     = ST_FULL;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef IF_ID_SKID_EN
        ST_FULL: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= '0;
      stall_cnt_q <= '0;
`ifdef IF_ID_SKID_EN
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef IF_ID_SKID_EN
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - checks if_id_buffer against a queue model, directed then random.
`timescale 1ns/1ps
module tb_if_id_buffer;

  localparam int AW = 8;
  localparam int IW = 8;
  localparam int CW = 4;
`ifdef IF_ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [IW-1:0] in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_next;
  logic [IW-1:0] out_inst;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] q_pc[$];
  logic [IW-1:0] q_inst[$];
  int            m_cnt = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.ADDR_W(AW), .INST_W(IW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_pc_next(out_pc_next),
    .out_inst   (out_inst),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, compare outputs with the model, then advance the model at the edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [AW-1:0] pc, input logic [IW-1:0] inst, input logic ordy);
    logic          mv, mir, ifire, ofire;
    logic [AW-1:0] epc, epn;
    logic [IW-1:0] einst;
    logic [CW-1:0] ecnt;
    @(negedge clk);
    reset = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    mv    = (q_pc.size() > 0);
    mir   = (CAP == 2) ? (q_pc.size() < 2) : (!mv || ordy);
    epc   = mv ? q_pc[0] : '0;
    einst = mv ? q_inst[0] : '0;
    epn   = epc + 8'd1;
    ecnt  = CW'(m_cnt);
    check("out_valid",   16'(out_valid),   16'(mv));
    check("in_ready",    16'(in_ready),    16'(mir));
    check("out_pc",      16'(out_pc),      16'(epc));
    check("out_pc_next", 16'(out_pc_next), 16'(epn));
    check("out_inst",    16'(out_inst),    16'(einst));
    check("stall_cnt",   16'(stall_cnt),   16'(ecnt));
    ifire = iv && mir;
    ofire = mv && ordy;
    @(posedge clk);
    if (r) begin
      q_pc.delete(); q_inst.delete(); m_cnt = 0;
    end else begin
      if (mv && !ordy && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      if (f) begin
        q_pc.delete(); q_inst.delete();
      end else begin
        if (ofire) begin
          void'(q_pc.pop_front()); void'(q_inst.pop_front());
        end
        if (ifire) begin
          q_pc.push_back(pc); q_inst.push_back(inst);
        end
      end
    end
  endtask

  initial begin
    logic r, f, iv, ordy;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 8'h00, 8'h00, 0);

    // Streaming at full rate.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(i), 8'(8'h10 + i), 1);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    step(0, 0, 0, 8'h00, 8'h00, 1);

    // Back-pressure then drain.
    step(0, 0, 1, 8'h20, 8'h a0, 0);
    step(0, 0, 1, 8'h21, 8'h a1, 0);
    repeat (3) step(0, 0, 0, 8'h00, 8'h00, 0);
    repeat (3) step(0, 0, 0, 8'h00, 8'h00, 1);

    // Flush from a full buffer with a same-cycle fetch.
    step(0, 0, 1, 8'h40, 8'h c0, 0);
    step(0, 0, 1, 8'h41, 8'h c1, 0);
    step(0, 1, 1, 8'h30, 8'h b0, 0);
    repeat (2) step(0, 0, 0, 8'h00, 8'h00, 1);

    // PC wrap.
    step(0, 0, 1, 8'hff, 8'h5a, 1);
    step(0, 0, 0, 8'h00, 8'h00, 1);

    // Counter saturation.
    step(0, 0, 1, 8'h50, 8'h d0, 0);
    repeat ((1 << CW) + 5) step(0, 0, 0, 8'h00, 8'h00, 0);

    // Reset while full with a nonzero counter.
    step(0, 0, 1, 8'h51, 8'h d1, 0);
    step(1, 0, 1, 8'h52, 8'h d2, 1);
    repeat (3) step(0, 0, 0, 8'h00, 8'h00, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 63) == 0);
      f    = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 3) != 0;
      pc   = 8'($urandom);
      inst = 8'($urandom);
      step(r, f, iv, pc, inst, ordy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
